ram_dp_clr: RTL and testbench
=============================

Name: ram_dp_clr

Overview:
- Synchronous true dual-port RAM model, parametrised in data width, depth, byte lanes, read latency and read-during-write mode.
- Includes a hardware clear sequencer that zero-fills (or CLEAR_VAL-fills) the array after reset or on request, replacing time-zero initial clearing.
- Used for work RAMs, palette RAM and sprite/tile RAMs, in simulation and synthesis alike.

Parameters:
- DATA_BITS, 16, word width; must be a multiple of 8.
- ADDR_BITS, 11, address width; depth = 2**ADDR_BITS.
- RD_LATENCY, 1, read latency in clocks; 1 or 2 only.
- RDW_NEW, 0, same-port read-during-write: 1 = new (merged) data, 0 = old data.
- CLEAR_VAL, 0, DATA_BITS fill value used by the clear sequencer.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear_req  in  1  one-cycle pulse that restarts the clear sequence.
- busy  out  1  high while the clear sequence runs.
- a_en  in  1  port A enable.
- a_we  in  1  port A write (effective only with a_en).
- a_be  in  DATA_BITS/8  port A byte-lane enables; bit i covers data[8i+7:8i].
- a_addr  in  ADDR_BITS  port A address.
- a_din  in  DATA_BITS  port A write data.
- a_dout  out  DATA_BITS  port A read data.
- b_en, b_we, b_be, b_addr, b_din, b_dout: identical set for port B.

Behaviour:
- Reset (async assert): busy=1, clear counter=0, both dout and any pipeline registers = CLEAR_VAL. Array contents are not touched asynchronously.
- FSM has two states, CLEAR and IDLE. Reset enters CLEAR.
- CLEAR: each clock writes CLEAR_VAL to mem[cnt] and increments cnt. On the clock that writes the last address (2**ADDR_BITS-1), move to IDLE and drop busy. Full fill takes exactly 2**ADDR_BITS clocks after reset deassert.
- clear_req in IDLE: enter CLEAR with cnt=0 and busy=1 on the next edge.
- clear_req in CLEAR: restart cnt at 0.
- While busy: port accesses are ignored (no writes), and dout holds CLEAR_VAL.
- Write (IDLE, en & we): on the edge, write only the bytes whose be bit is set; other lanes keep their value. be=0 means no write.
- Read (IDLE, en, any we):
  - RD_LATENCY=1: dout updates on the same edge that samples the address.
  - RD_LATENCY=2: an extra output register delays dout by one more edge.
  - en=0: dout holds its last value, and the pipeline stage also holds.
- Same-port read-during-write: RDW_NEW=1 returns the written word merged with the unmodified lanes; RDW_NEW=0 returns the pre-write word.
- Cross-port: a read on one port at the address the other port writes in the same cycle returns old data. The written value is visible from the next cycle.
- Write collision (both ports write the same address in the same cycle): port A wins on every lane A enables; B lanes are written only where a_be bit=0.
- Reset asserted mid-CLEAR or mid-read: sequence restarts from 0 and pipeline registers clear to CLEAR_VAL.
- Address is never out of range because depth is a power of two; the counter wraps only via the FSM exit.

Test Plan:
- Reset release with ADDR_BITS=4, CLEAR_VAL=16'hAAAA -> busy high exactly 16 clocks; afterwards reads of addr 0..15 all return 16'hAAAA, with dout valid 1 clock after address (RD_LATENCY=1).
- Port A writes 16'h1234 at addr 5 with be=2'b11, then 16'hFF00 with be=2'b01 -> port B read of addr 5 returns 16'h1200.
- RDW_NEW=0 vs 1: mem[3]=16'h0001, then port A write 16'hBEEF at addr 3 with en=1 -> a_dout = 16'h0001 (mode 0) / 16'hBEEF (mode 1). Same cycle port B read of addr 3 = 16'h0001 in both modes.
- Collision at addr 7: A writes 16'h1111 be=2'b10, B writes 16'h2222 be=2'b11 -> mem[7]=16'h1122.
- RD_LATENCY=2: address 9 (holding 16'h0909) presented at edge N with en=1 -> b_dout = 16'h0909 after edge N+1, not before. Holding en=0 afterwards keeps the value.
- clear_req in IDLE, then a write attempted while busy, then reset pulse mid-clear -> write discarded, busy stays high for a full 16 clocks from the reset release, and all words equal CLEAR_VAL.

Source files
------------

// File: rtl/ram_dp_clr.sv
// rtl/ram_dp_clr.sv - true dual-port RAM with byte lanes and a hardware clear sequencer
//
// Purpose: synchronous true dual-port RAM for work, palette and sprite/tile RAMs.
// After reset, or on a clear_req pulse, a sequencer fills every word with CLEAR_VAL.
// While that fill runs, both ports are locked out.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   clear_req           one-cycle pulse that (re)starts the fill from address 0
//   busy                high while the fill runs
//   a_en/b_en           port enable (a read happens on every enabled cycle)
//   a_we/b_we           write qualifier, effective only with the enable
//   a_be/b_be           byte-lane write enables, bit i covers data[8i+7:8i]
//   a_addr/b_addr       word address
//   a_din/b_din         write data
//   a_dout/b_dout       read data, RD_LATENCY (1 or 2) clocks after the address
module ram_dp_clr #(
   parameter int                   DATA_BITS  = 16,
   parameter int                   ADDR_BITS  = 11,
   parameter int                   RD_LATENCY = 1,
   parameter int                   RDW_NEW    = 0,
   parameter logic [DATA_BITS-1:0] CLEAR_VAL  = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear_req,
   output logic                   busy,
   input  logic                   a_en,
   input  logic                   a_we,
   input  logic [DATA_BITS/8-1:0] a_be,
   input  logic [ADDR_BITS-1:0]   a_addr,
   input  logic [DATA_BITS-1:0]   a_din,
   output logic [DATA_BITS-1:0]   a_dout,
   input  logic                   b_en,
   input  logic                   b_we,
   input  logic [DATA_BITS/8-1:0] b_be,
   input  logic [ADDR_BITS-1:0]   b_addr,
   input  logic [DATA_BITS-1:0]   b_din,
   output logic [DATA_BITS-1:0]   b_dout
);

   localparam int                   LANES     = DATA_BITS / 8;
   localparam int                   DEPTH     = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
   logic [DATA_BITS-1:0]   mem [DEPTH];

   // Replace the lanes selected by 'lanes' in 'old' with the matching bytes of 'din'.
   function automatic logic [DATA_BITS-1:0] merge_lanes(
      input logic [DATA_BITS-1:0] old,
      input logic [DATA_BITS-1:0] din,
      input logic [LANES-1:0]     lanes
   );
      logic [DATA_BITS-1:0] w;
      w = old;
      for (int i = 0; i < LANES; i++) begin
         if (lanes[i]) begin
            w[8*i +: 8] = din[8*i +: 8];
         end
      end
      return w;
   endfunction

   // ---------------------------------------------------------------- clear FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy    = (state_q == S_CLEAR);
      case (state_q)
         S_CLEAR: begin
            if (clear_req) begin
               cnt_d = '0;
            end else if (cnt_q == LAST_ADDR) begin
               // This edge writes the last word; the array is fully filled.
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_ONE;
            end
         end
         S_IDLE: begin
            if (clear_req) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------- port qualification
   logic                 idle;
   logic [LANES-1:0]     a_lanes, b_lanes;
   logic [DATA_BITS-1:0] a_old, b_old, a_rdata, b_rdata;

   assign idle    = (state_q == S_IDLE);
   assign a_lanes = {LANES{idle & a_en & a_we}} & a_be;
   assign b_lanes = {LANES{idle & b_en & b_we}} & b_be;
   assign a_old   = mem[a_addr];
   assign b_old   = mem[b_addr];

   // Same-port read-during-write sees its own write only in RDW_NEW mode; the other
   // port's write is never forwarded, so cross-port reads always return old data.
   assign a_rdata = (RDW_NEW != 0) ? merge_lanes(a_old, a_din, a_lanes) : a_old;
   assign b_rdata = (RDW_NEW != 0) ? merge_lanes(b_old, b_din, b_lanes) : b_old;

   // ---------------------------------------------------------------- array
   // Port A lane writes are issued after port B's, so on an address collision A
   // owns every lane it enables and B lands only on the remaining lanes.
   always_ff @(posedge clk) begin
      if (state_q == S_CLEAR) begin
         mem[cnt_q] <= CLEAR_VAL;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (b_lanes[i]) begin
               mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
            end
         end
         for (int i = 0; i < LANES; i++) begin
            if (a_lanes[i]) begin
               mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------- read pipeline
   // A clear_req seen in IDLE flushes the outputs on the same edge that raises busy,
   // so dout reads CLEAR_VAL for the whole time busy is high.
   logic                 pipe_clr;
   logic [DATA_BITS-1:0] a_s1_q, b_s1_q;

   assign pipe_clr = (state_q == S_CLEAR) | clear_req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_s1_q <= CLEAR_VAL;
         b_s1_q <= CLEAR_VAL;
      end else if (pipe_clr) begin
         a_s1_q <= CLEAR_VAL;
         b_s1_q <= CLEAR_VAL;
      end else begin
         if (a_en) a_s1_q <= a_rdata;
         if (b_en) b_s1_q <= b_rdata;
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                 a_v_q, b_v_q;
         logic [DATA_BITS-1:0] a_s2_q, b_s2_q;

         // The output stage takes stage 1 only on the edge after a read, so a
         // pending read still lands while en is low and dout then holds.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               a_v_q  <= 1'b0;
               b_v_q  <= 1'b0;
               a_s2_q <= CLEAR_VAL;
               b_s2_q <= CLEAR_VAL;
            end else if (pipe_clr) begin
               a_v_q  <= 1'b0;
               b_v_q  <= 1'b0;
               a_s2_q <= CLEAR_VAL;
               b_s2_q <= CLEAR_VAL;
            end else begin
               a_v_q <= a_en;
               b_v_q <= b_en;
               if (a_v_q) a_s2_q <= a_s1_q;
               if (b_v_q) b_s2_q <= b_s1_q;
            end
         end

         assign a_dout = a_s2_q;
         assign b_dout = b_s2_q;
      end else begin : g_lat1
         assign a_dout = a_s1_q;
         assign b_dout = b_s1_q;
      end
   endgenerate

endmodule

// File: tb/tb_ram_dp_clr.sv
// tb/tb_ram_dp_clr.sv - self-checking bench for ram_dp_clr (three configurations in parallel)
module tb_ram_dp_clr;

   localparam logic [15:0] CV = 16'hAAAA;

   logic        clk = 1'b0;
   logic        reset, clear_req;
   logic        a_en, a_we, b_en, b_we;
   logic [1:0]  a_be, b_be;
   logic [3:0]  a_addr, b_addr;
   logic [15:0] a_din, b_din;

   logic        busy0, busy1, busy2;
   logic [15:0] a_dout0, b_dout0, a_dout1, b_dout1, a_dout2, b_dout2;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   always #5 clk = ~clk;

   // dut0: latency 1, old data; dut1: latency 1, new data; dut2: latency 2, old data.
   ram_dp_clr #(.DATA_BITS(16), .ADDR_BITS(4), .RD_LATENCY(1), .RDW_NEW(0), .CLEAR_VAL(CV)) dut0 (
      .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy0),
      .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout0),
      .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout0));
   ram_dp_clr #(.DATA_BITS(16), .ADDR_BITS(4), .RD_LATENCY(1), .RDW_NEW(1), .CLEAR_VAL(CV)) dut1 (
      .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy1),
      .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout1),
      .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout1));
   ram_dp_clr #(.DATA_BITS(16), .ADDR_BITS(4), .RD_LATENCY(2), .RDW_NEW(0), .CLEAR_VAL(CV)) dut2 (
      .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy2),
      .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout2),
      .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout2));

   // ---------------------------------------------------------------- reference model
   typedef struct {
      bit          v;
      logic [15:0] old_w;
      logic [15:0] new_w;
   } rd_t;

   logic [15:0] ref_mem [16];
   bit          m_busy;
   int          m_cnt;
   rd_t         ha[$];
   rd_t         hb[$];

   function automatic logic [15:0] lanes_over(input logic [15:0] base, input logic [15:0] din,
                                              input logic [1:0] lanes);
      logic [15:0] m;
      m = {{8{lanes[1]}}, {8{lanes[0]}}};
      return (base & ~m) | (din & m);
   endfunction

   // Output after an edge = most recent read issued at least (latency-1) edges ago.
   function automatic logic [15:0] exp_dout(input rd_t h[$], input int skip, input bit use_new);
      for (int i = h.size() - 1 - skip; i >= 0; i--) begin
         if (h[i].v) return use_new ? h[i].new_w : h[i].old_w;
      end
      return CV;
   endfunction

   task automatic model_reset();
      m_busy = 1'b1;
      m_cnt  = 0;
      ha.delete();
      hb.delete();
   endtask

   task automatic model_edge();
      rd_t         ea, eb;
      logic [1:0]  la, lb;
      if (reset) return;
      if (m_busy) begin
         ref_mem[m_cnt] = CV;
         ha.delete();
         hb.delete();
         if (clear_req) m_cnt = 0;
         else if (m_cnt == 15) begin
            m_busy = 1'b0;
            m_cnt  = 0;
         end else m_cnt++;
      end else begin
         la = (a_en && a_we) ? a_be : 2'b00;
         lb = (b_en && b_we) ? b_be : 2'b00;
         ea.v = a_en; ea.old_w = ref_mem[a_addr]; ea.new_w = lanes_over(ref_mem[a_addr], a_din, la);
         eb.v = b_en; eb.old_w = ref_mem[b_addr]; eb.new_w = lanes_over(ref_mem[b_addr], b_din, lb);
         ha.push_back(ea);
         hb.push_back(eb);
         ref_mem[b_addr] = lanes_over(ref_mem[b_addr], b_din, lb);
         ref_mem[a_addr] = lanes_over(ref_mem[a_addr], a_din, la);
         if (clear_req) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            ha.delete();
            hb.delete();
         end
      end
   endtask

   // ---------------------------------------------------------------- checking
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("busy0", 32'(busy0), 32'(m_busy));
      check("busy1", 32'(busy1), 32'(m_busy));
      check("busy2", 32'(busy2), 32'(m_busy));
      check("a_dout0", 32'(a_dout0), 32'(exp_dout(ha, 0, 1'b0)));
      check("b_dout0", 32'(b_dout0), 32'(exp_dout(hb, 0, 1'b0)));
      check("a_dout1", 32'(a_dout1), 32'(exp_dout(ha, 0, 1'b1)));
      check("b_dout1", 32'(b_dout1), 32'(exp_dout(hb, 0, 1'b1)));
      check("a_dout2", 32'(a_dout2), 32'(exp_dout(ha, 1, 1'b0)));
      check("b_dout2", 32'(b_dout2), 32'(exp_dout(hb, 1, 1'b0)));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic ports_idle();
      a_en = 0; a_we = 0; a_be = 2'b00; a_addr = 4'd0; a_din = 16'h0;
      b_en = 0; b_we = 0; b_be = 2'b00; b_addr = 4'd0; b_din = 16'h0;
   endtask

   task automatic wait_clear(input string tag);
      int n;
      n = 0;
      while (busy0 && n < 40) begin
         tick();
         n++;
      end
      check(tag, 32'(n), 32'd16);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int n;
      reset = 1'b1;
      clear_req = 1'b0;
      ports_idle();
      model_reset();
      #2;
      check_all();
      check("reset_a_dout", 32'(a_dout2), 32'(CV));
      tick();
      tick();

      // Reset release: busy for exactly 16 clocks, then every word reads CLEAR_VAL.
      reset = 1'b0;
      wait_clear("busy_len_after_reset");
      for (int i = 0; i < 16; i++) begin
         a_en = 1; a_addr = 4'(i);
         tick();
         check("fill_read", 32'(a_dout0), 32'(CV));
      end
      ports_idle();

      // Byte-lane write: 1234 full, then FF00 low lane only -> 1200.
      a_en = 1; a_we = 1; a_be = 2'b11; a_addr = 4'd5; a_din = 16'h1234;
      tick();
      a_be = 2'b01; a_din = 16'hFF00;
      tick();
      ports_idle();
      b_en = 1; b_addr = 4'd5;
      tick();
      check("be_merge", 32'(b_dout0), 32'h1200);
      ports_idle();

      // Read-during-write: same port old/new, cross port always old.
      a_en = 1; a_we = 1; a_be = 2'b11; a_addr = 4'd3; a_din = 16'h0001;
      tick();
      a_din = 16'hBEEF;
      b_en = 1; b_addr = 4'd3;
      tick();
      check("rdw_old", 32'(a_dout0), 32'h0001);
      check("rdw_new", 32'(a_dout1), 32'hBEEF);
      check("xport_old0", 32'(b_dout0), 32'h0001);
      check("xport_old1", 32'(b_dout1), 32'h0001);
      ports_idle();

      // Write collision at addr 7: A owns its lane, B fills the rest.
      a_en = 1; a_we = 1; a_be = 2'b10; a_addr = 4'd7; a_din = 16'h1111;
      b_en = 1; b_we = 1; b_be = 2'b11; b_addr = 4'd7; b_din = 16'h2222;
      tick();
      ports_idle();
      a_en = 1; a_addr = 4'd7;
      tick();
      check("collision", 32'(a_dout0), 32'h1122);
      ports_idle();

      // Latency 2: address at edge N, data after N+1, held while en stays low.
      a_en = 1; a_we = 1; a_be = 2'b11; a_addr = 4'd9; a_din = 16'h0909;
      tick();
      ports_idle();
      tick();
      b_en = 1; b_addr = 4'd9;
      tick();
      total++;
      assert (b_dout2 !== 16'h0909) passed++;
      else begin
         failed++;
         $error("FAIL lat2_early: observed %h expected not 0909", b_dout2);
      end
      b_en = 0;
      tick();
      check("lat2_data", 32'(b_dout2), 32'h0909);
      tick();
      check("lat2_hold", 32'(b_dout2), 32'h0909);

      // clear_req, write while busy, reset pulse mid-clear.
      clear_req = 1;
      tick();
      clear_req = 0;
      check("clear_req_busy", 32'(busy0), 32'd1);
      a_en = 1; a_we = 1; a_be = 2'b11; a_addr = 4'd2; a_din = 16'h5555;
      tick();
      ports_idle();
      tick();
      tick();
      reset = 1'b1;
      model_reset();
      #1;
      check_all();
      tick();
      reset = 1'b0;
      wait_clear("busy_len_after_midreset");
      for (int i = 0; i < 16; i++) begin
         a_en = 1; a_addr = 4'(i);
         b_en = 1; b_addr = 4'(15 - i);
         tick();
         check("clr_a", 32'(a_dout0), 32'(CV));
         check("clr_b", 32'(b_dout0), 32'(CV));
      end
      ports_idle();

      // Randomised traffic against the model, with a reset pulse partway through.
      for (int i = 0; i < 300; i++) begin
         a_en = 1'($urandom); a_we = 1'($urandom); a_be = 2'($urandom);
         a_addr = 4'($urandom_range(0, 15)); a_din = 16'($urandom);
         b_en = 1'($urandom); b_we = 1'($urandom); b_be = 2'($urandom);
         b_addr = ($urandom_range(0, 3) == 0) ? a_addr : 4'($urandom_range(0, 15));
         b_din = 16'($urandom);
         if (i == 150) begin
            reset = 1'b1;
            model_reset();
            #1;
            check_all();
            tick();
            reset = 1'b0;
         end else begin
            tick();
         end
      end
      ports_idle();
      n = 0;
      while (busy0 && n < 40) begin
         tick();
         n++;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
